tdm_demux_1_4: RTL and testbench

TDM_DEMUX_1_4 -- requirements
Module: tdm_demux_1_4

---
 rtl/tdm_pkg.sv | 6 +
 rtl/tdm_slot_ctr.sv | 15 +
 rtl/tdm_demux_1_4.sv | 76 +++++++
 tb/tb_tdm_demux_1_4.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/tdm_pkg.sv
// tdm_pkg: shared slot-count constants and framing state type for the TDM demux
package tdm_pkg;
  localparam int NUM_SLOTS = 4;
  localparam int SLOT_W = 2;
  typedef enum logic {HUNT, LOCK} state_t;
endpackage

// File: rtl/tdm_slot_ctr.sv
// tdm_slot_ctr: mod-4 slot counter with clear, load-1 and increment controls
module tdm_slot_ctr
  import tdm_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inc,
  input  logic              clr,
  input  logic              ld1,
  output logic [SLOT_W-1:0] slot
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) slot <= '0;
    else slot <= clr ? '0 : ld1 ? SLOT_W'(1) : inc ? slot + SLOT_W'(1) : slot;
endmodule

// File: rtl/tdm_demux_1_4.sv
// tdm_demux_1_4: frame-synchronised 1-to-4 TDM demultiplexer with HUNT/LOCK framing
module tdm_demux_1_4
  import tdm_pkg::*;
#(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] y,
  input  logic         valid_in,
  input  logic         frame_sync,
  output logic [W-1:0] d0,
  output logic [W-1:0] d1,
  output logic [W-1:0] d2,
  output logic [W-1:0] d3,
  output logic         sel1,
  output logic         sel0,
  output logic         frame_valid,
  output logic         locked,
  output logic         sync_err
);
  localparam logic [SLOT_W-1:0] LAST = SLOT_W'(NUM_SLOTS - 1);
  state_t state;
  logic [SLOT_W-1:0] slot;
  logic [W-1:0] s0, s1, s2;
  logic inc, clr, ld1;
  always_comb begin
    ld1 = valid_in && frame_sync;
    clr = valid_in && !frame_sync && state == LOCK && slot == '0;
    inc = valid_in && !frame_sync && state == LOCK && slot != '0;
  end
  tdm_slot_ctr u_ctr (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (inc),
    .clr  (clr),
    .ld1  (ld1),
    .slot (slot)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state       <= HUNT;
      s0          <= '0;
      s1          <= '0;
      s2          <= '0;
      d0          <= '0;
      d1          <= '0;
      d2          <= '0;
      d3          <= '0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
      if (valid_in && frame_sync) begin
        state    <= LOCK;
        s0       <= y;
        sync_err <= state == LOCK && slot != '0;
      end else if (valid_in && state == LOCK) begin
        state <= slot == '0 ? HUNT : LOCK;
        sync_err <= slot == '0;
        s1 <= slot == SLOT_W'(1) ? y : s1;
        s2 <= slot == SLOT_W'(2) ? y : s2;
        if (slot == LAST) begin
          d0          <= s0;
          d1          <= s1;
          d2          <= s2;
          d3          <= y;
          frame_valid <= 1'b1;
        end
      end
    end
  assign locked = state == LOCK;
  assign sel1 = slot[1];
  assign sel0 = slot[0];
endmodule

// File: tb/tb_tdm_demux_1_4.sv
// tb_tdm_demux_1_4: randomized and directed check of tdm_demux_1_4 against a frame-queue model
module tb_tdm_demux_1_4;
  localparam int W = 4;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [W-1:0] y = '0;
  logic valid_in = 1'b0, frame_sync = 1'b0;
  logic [W-1:0] d0, d1, d2, d3;
  logic sel1, sel0, frame_valid, locked, sync_err;
  int checks = 0, errors = 0;
  bit lk;
  bit efv, ese;
  logic [W-1:0] q[$];
  logic [W-1:0] ed[4];
  int nfv;
  tdm_demux_1_4 #(.W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .y          (y),
    .valid_in   (valid_in),
    .frame_sync (frame_sync),
    .d0         (d0),
    .d1         (d1),
    .d2         (d2),
    .d3         (d3),
    .sel1       (sel1),
    .sel0       (sel0),
    .frame_valid(frame_valid),
    .locked     (locked),
    .sync_err   (sync_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    lk = 0;
    q.delete();
    for (int i = 0; i < 4; i++) ed[i] = '0;
    efv = 0;
    ese = 0;
  endtask
  task automatic model(input bit v, input bit f, input logic [W-1:0] d);
    efv = 0;
    ese = 0;
    if (!v) return;
    if (f) begin
      ese = lk && q.size() != 0;
      lk = 1;
      q.delete();
      q.push_back(d);
    end else if (lk) begin
      if (q.size() == 0) begin
        ese = 1;
        lk = 0;
      end else begin
        q.push_back(d);
        if (q.size() == 4) begin
          for (int i = 0; i < 4; i++) ed[i] = q[i];
          efv = 1;
          q.delete();
        end
      end
    end
  endtask
  task automatic check_all();
    chk("dout", 32'({d3, d2, d1, d0}), 32'({ed[3], ed[2], ed[1], ed[0]}));
    chk("sel", 32'({sel1, sel0}), 32'(q.size()));
    chk("frame_valid", 32'(frame_valid), 32'(efv));
    chk("locked", 32'(locked), 32'(lk));
    chk("sync_err", 32'(sync_err), 32'(ese));
    if (frame_valid) nfv++;
  endtask
  task automatic step(input bit v, input bit f, input logic [W-1:0] d);
    @(negedge clk);
    valid_in = v;
    frame_sync = f;
    y = d;
    @(posedge clk);
    model(v, f, d);
    #1 check_all();
  endtask
  task automatic gap(input int n);
    for (int i = 0; i < n; i++) step(0, $urandom_range(0, 1), W'($urandom));
  endtask
  initial begin
    model_reset();
    #1 check_all();
    @(negedge clk);
    rst_n = 1'b1;
    nfv = 0;
    step(1, 1, 1);
    chk("req28_locked", 32'(locked), 32'd1);
    step(1, 0, 2);
    step(1, 0, 3);
    step(1, 0, 4);
    chk("req28_dout", 32'({d3, d2, d1, d0}), 32'h4321);
    step(0, 0, 0);
    chk("req28_one_pulse", 32'(nfv), 32'd1);
    nfv = 0;
    step(1, 1, 1); gap(2);
    step(1, 0, 2); gap(2);
    step(1, 0, 3); gap(2);
    step(1, 0, 4); gap(2);
    chk("req29_one_pulse", 32'(nfv), 32'd1);
    step(1, 1, 5);
    step(1, 0, 6);
    step(1, 1, 10);
    chk("req30_dout_held", 32'({d3, d2, d1, d0}), 32'h4321);
    step(1, 0, 7);
    step(1, 0, 8);
    step(1, 0, 9);
    chk("req30_dout", 32'({d3, d2, d1, d0}), 32'h987a);
    step(1, 0, 11);
    chk("req31_unlock", 32'({locked, sel1, sel0, sync_err}), 32'b0001);
    step(1, 0, 12);
    for (int k = 0; k < 4; k++) step(1, k == 0, W'(k + 12));
    chk("req31_relock", 32'({d3, d2, d1, d0}), 32'hfedc);
    nfv = 0;
    for (int k = 0; k < 16; k++) begin
      step(1, k % 4 == 0, W'(k));
      chk("req33_sel", 32'({sel1, sel0}), 32'((k + 1) % 4));
    end
    chk("req33_pulses", 32'(nfv), 32'd4);
    step(1, 1, 1);
    step(1, 0, 2);
    step(1, 0, 3);
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_all();
    @(negedge clk);
    valid_in = 1'b0;
    frame_sync = 1'b0;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) step(1, 0, W'(k + 5));
    chk("req32_hunt", 32'(locked), 32'd0);
    for (int n = 0; n < 2000; n++) begin
      bit v, f;
      v = $urandom_range(0, 3) != 0;
      f = $urandom_range(0, 15) == 0 || (q.size() == 0 && $urandom_range(0, 3) != 0);
      step(v, f, W'($urandom));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
